// File: rtl/adder_seq.sv
// Multi-cycle WIDTH-bit add/subtract unit: one CHUNK-bit carry-lookahead slice is iterated
// LSB chunk first, with the inter-chunk carry held in a flop. Valid/ready on both sides.
module adder_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("adder_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [CHUNK-1:0]  ca, cb, cp, cg, cs;
  logic [CHUNK:0]    cc;
  logic              pp;

  // Chunk slice: each carry is a flat sum of generate terms gated by the propagate chain
  // below them, so no carry depends on a lower-order carry output.
  always_comb begin
    ca    = a_q[cnt_q*CHUNK +: CHUNK];
    cb    = b_q[cnt_q*CHUNK +: CHUNK];
    cp    = ca ^ cb;
    cg    = ca & cb;
    cc    = '0;
    pp    = 1'b0;
    cc[0] = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      cc[i+1] = cg[i];
      pp      = cp[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc[i+1] = cc[i+1] | (pp & cg[j]);
        pp      = pp & cp[j];
      end
      cc[i+1] = cc[i+1] | (pp & carry_q);
    end
    cs = cp ^ cc[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | carry_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[cnt_q*CHUNK +: CHUNK] = cs;
        carry_d = cc[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          cout_d  = cc[CHUNK];
          ovf_d   = cc[CHUNK] ^ cc[CHUNK-1];
          zero_d  = (sum_d == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

`ifdef FORMAL
  logic c0_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) c0_q <= 1'b0;
    else if (state_q == StIdle && in_valid) c0_q <= sub | carry_in;
  end
  assert property (@(posedge clk) disable iff (reset)
    (state_q == StDone) |->
      ({cout_q, sum_q} == ({1'b0, a_q} + {1'b0, b_q} + (WIDTH + 1)'(c0_q))));
`endif

endmodule
